// File: rtl/bank_isu_arbiter.sv
// bank_isu_arbiter: picks one of linefill, write-back or four round-robin channels and issues it to the SRAM controller.
// Channels get a starvation escape after STARVE_LIMIT back-to-back linefill/write-back grants.
module bank_isu_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [3:0]   ch_valid_i,
    output logic [3:0]   ch_ready_o,
    input  logic [3:0]   ch_is_read_i,
    input  logic [27:0]  ch_set_way_offset_i,
    input  logic [31:0]  ch_wbuffer_id_i,
    input  logic [11:0]  ch_rob_num_i,
    input  logic         lf_valid_i,
    output logic         lf_ready_o,
    input  logic [1:0]   lf_channel_id_i,
    input  logic [2:0]   lf_rob_num_i,
    input  logic [6:0]   lf_set_way_offset_i,
    input  logic [1:0]   lf_dirty_offset0_i,
    input  logic [1:0]   lf_dirty_offset1_i,
    input  logic [127:0] lf_data_offset0_i,
    input  logic [127:0] lf_data_offset1_i,
    input  logic         wb_valid_i,
    output logic         wb_ready_o,
    input  logic [6:0]   wb_set_way_offset_i,
    input  logic [1:0]   wb_dirty_offset0_i,
    input  logic [1:0]   wb_dirty_offset1_i,
    output logic         isu_sc_valid_o,
    input  logic         isu_sc_ready_i,
    output logic [1:0]   isu_sc_channel_id_o,
    output logic [2:0]   isu_sc_opcode_o,
    output logic [6:0]   isu_sc_set_way_offset_o,
    output logic [7:0]   isu_sc_wbuffer_id_o,
    output logic [2:0]   isu_sc_xbar_rob_num_o,
    output logic [1:0]   isu_sc_cacheline_dirty_offset0_o,
    output logic [1:0]   isu_sc_cacheline_dirty_offset1_o,
    output logic [127:0] isu_sc_linefill_data_offset0_o,
    output logic [127:0] isu_sc_linefill_data_offset1_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state;
    logic [1:0] rr_ptr, ch_sel;
    logic [2:0] starve_cnt, c_rob;
    logic [6:0] c_swo;
    logic [7:0] c_wbuf;
    logic       c_rd, grant, any_ch, starved, lf_win, wb_win, ch_win, win;
    // Readies stay low while reset is held so nothing is consumed and dropped
    assign grant   = rst_ni && (state == IDLE || isu_sc_ready_i);
    assign any_ch  = |ch_valid_i;
    assign starved = any_ch && starve_cnt == 3'(STARVE_LIMIT);
    assign lf_win  = grant && lf_valid_i && !starved;
    assign wb_win  = grant && wb_valid_i && !lf_valid_i && !starved;
    assign ch_win  = grant && any_ch && (starved || !(lf_valid_i || wb_valid_i));
    assign win     = lf_win || wb_win || ch_win;
    assign isu_sc_valid_o = state == BUSY;
    assign lf_ready_o = lf_win;
    assign wb_ready_o = wb_win;
    assign ch_ready_o = ch_win ? 4'b0001 << ch_sel : 4'b0000;
    // Scan downward so the closest valid channel at or after rr_ptr is written last
    always_comb begin
        ch_sel = rr_ptr;
        c_swo  = '0;
        c_wbuf = '0;
        c_rob  = '0;
        c_rd   = 1'b0;
        for (int i = 3; i >= 0; i--)
            if (ch_valid_i[rr_ptr + 2'(i)]) ch_sel = rr_ptr + 2'(i);
        for (int i = 0; i < 4; i++)
            if (ch_sel == 2'(i)) begin
                c_swo  = ch_set_way_offset_i[7*i +: 7];
                c_wbuf = ch_wbuffer_id_i[8*i +: 8];
                c_rob  = ch_rob_num_i[3*i +: 3];
                c_rd   = ch_is_read_i[i];
            end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                            <= IDLE;
            rr_ptr                           <= '0;
            starve_cnt                       <= '0;
            isu_sc_channel_id_o              <= '0;
            isu_sc_opcode_o                  <= '0;
            isu_sc_set_way_offset_o          <= '0;
            isu_sc_wbuffer_id_o              <= '0;
            isu_sc_xbar_rob_num_o            <= '0;
            isu_sc_cacheline_dirty_offset0_o <= '0;
            isu_sc_cacheline_dirty_offset1_o <= '0;
            isu_sc_linefill_data_offset0_o   <= '0;
            isu_sc_linefill_data_offset1_o   <= '0;
        end else begin
            if (grant) state <= win ? BUSY : IDLE;
            if (lf_win) begin
                isu_sc_channel_id_o              <= lf_channel_id_i;
                isu_sc_opcode_o                  <= 3'd2;
                isu_sc_set_way_offset_o          <= lf_set_way_offset_i;
                isu_sc_wbuffer_id_o              <= '0;
                isu_sc_xbar_rob_num_o            <= lf_rob_num_i;
                isu_sc_cacheline_dirty_offset0_o <= lf_dirty_offset0_i;
                isu_sc_cacheline_dirty_offset1_o <= lf_dirty_offset1_i;
                isu_sc_linefill_data_offset0_o   <= lf_data_offset0_i;
                isu_sc_linefill_data_offset1_o   <= lf_data_offset1_i;
            end
            if (wb_win) begin
                isu_sc_channel_id_o              <= '0;
                isu_sc_opcode_o                  <= 3'd3;
                isu_sc_set_way_offset_o          <= wb_set_way_offset_i;
                isu_sc_wbuffer_id_o              <= '0;
                isu_sc_xbar_rob_num_o            <= '0;
                isu_sc_cacheline_dirty_offset0_o <= wb_dirty_offset0_i;
                isu_sc_cacheline_dirty_offset1_o <= wb_dirty_offset1_i;
                isu_sc_linefill_data_offset0_o   <= '0;
                isu_sc_linefill_data_offset1_o   <= '0;
            end
            if (ch_win) begin
                isu_sc_channel_id_o              <= ch_sel;
                isu_sc_opcode_o                  <= {2'b00, c_rd};
                isu_sc_set_way_offset_o          <= c_swo;
                isu_sc_wbuffer_id_o              <= c_wbuf;
                isu_sc_xbar_rob_num_o            <= c_rob;
                isu_sc_cacheline_dirty_offset0_o <= '0;
                isu_sc_cacheline_dirty_offset1_o <= '0;
                isu_sc_linefill_data_offset0_o   <= '0;
                isu_sc_linefill_data_offset1_o   <= '0;
                rr_ptr                           <= ch_sel + 2'd1;
                starve_cnt                       <= '0;
            end else if ((lf_win || wb_win) && any_ch && starve_cnt != 3'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 3'd1;
        end
    end
endmodule
